pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_scoreboard.sv | 51 +++++
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline controller: FSM state encoding and the
// per-boundary scoreboard entry.
package pipe_pkg;

  // Widest register address the scoreboard entry can carry (AW must not exceed it).
  localparam int RD_W = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipeState_t;

  typedef struct packed {
    logic            valid;
    logic            wr;
    logic [RD_W-1:0] rd;
    logic            isLoad;
    logic            halt;
  } sbEntry_t;

endpackage

// File: rtl/pipe_scoreboard.sv
// Destination scoreboard for boundaries 1..NSTAGES-2; entry i of the array
// sits at boundary i+1 and follows that boundary's enable/flush.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int NSTAGES = 5,
  parameter int AW      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NSTAGES-3:0] advEn,
  input  logic [NSTAGES-3:0] flushEn,
  input  sbEntry_t         idEntry,
  input  logic [AW-1:0]    idRs,
  input  logic [AW-1:0]    idRt,
  output logic             ldLive,
  output logic             rsHit,
  output logic             rtHit,
  output logic             haltExit
);

  localparam int NE = NSTAGES - 2;

  sbEntry_t entries [NE];
  sbEntry_t src     [NE];

  always_comb begin
    src[0] = idEntry;
    for (int i = 1; i < NE; i++) src[i] = entries[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < NE; i++) begin
        if (advEn[i]) begin
          if (flushEn[i]) entries[i] <= '0;
          else            entries[i] <= src[i];
        end
      end
    end
  end

  assign ldLive   = entries[0].valid && entries[0].isLoad && entries[0].wr &&
                    (entries[0].rd != '0);
  assign rsHit    = (entries[0].rd == RD_W'(idRs));
  assign rtHit    = (entries[0].rd == RD_W'(idRt));
  assign haltExit = entries[NE-1].valid && entries[NE-1].halt;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: load-use stall, branch flush, memory back-pressure and halt drain
// sequencing. Define PIPE_CTRL_PERF_EN to build the stall/flush counters.
//
// state  | meaning
// RUN    | normal issue; a halt accepted in ID moves to DRAIN
// DRAIN  | PC frozen, ID bubbled, waiting for the halt to leave the last boundary
// HALTED | everything frozen, hlt high until reset
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int NSTAGES = 5,
  parameter int AW      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [AW-1:0]      id_rs,
  input  logic [AW-1:0]      id_rt,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic               id_wr,
  input  logic [AW-1:0]      id_rd,
  input  logic               id_is_load,
  input  logic               id_is_halt,
  input  logic               branch_take,
  input  logic               mem_busy,
  output logic [NSTAGES-2:0] stage_en,
  output logic [NSTAGES-2:0] stage_flush,
  output logic               pc_en,
  output logic               stall,
  output logic               hlt,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
);

  pipeState_t state;
  sbEntry_t   idEntry;
  logic       ldLive, rsHit, rtHit, haltExit;
  logic       stallHaz, haltAccept;

  assign stallHaz = id_valid && ldLive &&
                    ((id_uses_rs && rsHit) || (id_uses_rt && rtHit));
  assign stall    = stallHaz;

  // Only an accepted halt is tagged, so a halt dropped by a branch never ends the drain.
  assign haltAccept = (state == RUN) && id_valid && id_is_halt &&
                      !stallHaz && !mem_busy && !branch_take;

  always_comb begin
    idEntry        = '0;
    idEntry.valid  = id_valid;
    idEntry.wr     = id_wr;
    idEntry.rd     = RD_W'(id_rd);
    idEntry.isLoad = id_is_load;
    idEntry.halt   = haltAccept;
  end

  always_comb begin
    stage_en    = '1;
    stage_flush = '0;
    pc_en       = 1'b1;
    if (mem_busy || state == HALTED) begin
      stage_en = '0;
      pc_en    = 1'b0;
    end else if (stallHaz) begin
      stage_en[0]    = 1'b0;
      stage_flush[1] = 1'b1;
      pc_en          = 1'b0;
    end else if (state == DRAIN) begin
      stage_flush[0] = 1'b1;
      pc_en          = 1'b0;
    end else if (branch_take) begin
      stage_flush[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      hlt   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (haltAccept) state <= DRAIN;
        end
        DRAIN: begin
          if (!mem_busy && haltExit) begin
            state <= HALTED;
            hlt   <= 1'b1;
          end
        end
        HALTED: begin
          hlt <= 1'b1;
        end
        default: begin
          state <= RUN;
          hlt   <= 1'b0;
        end
      endcase
    end
  end

  pipe_scoreboard #(
    .NSTAGES(NSTAGES),
    .AW     (AW)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .advEn   (stage_en[NSTAGES-2:1]),
    .flushEn (stage_flush[NSTAGES-2:1]),
    .idEntry (idEntry),
    .idRs    (id_rs),
    .idRt    (id_rt),
    .ldLive  (ldLive),
    .rsHit   (rsHit),
    .rtHit   (rtHit),
    .haltExit(haltExit)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stallCnt, flushCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else if (state != HALTED) begin
      if ((stallHaz || mem_busy) && stallCnt != 32'hFFFF_FFFF) stallCnt <= stallCnt + 32'd1;
      if ((|stage_flush) && flushCnt != 32'hFFFF_FFFF)         flushCnt <= flushCnt + 32'd1;
    end
  end

  assign stall_cnt = stallCnt;
  assign flush_cnt = flushCnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
